// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer: Fill, Wash, Rinse, Spin timed by 1 s ticks,
// with coin start, optional double wash and a pause that applies only in Spin.
module wash_cycle_ctrl #(
   parameter int unsigned CNT_W   = 9,
   parameter int unsigned FILL_S  = 120,
   parameter int unsigned WASH_S  = 300,
   parameter int unsigned RINSE_S = 120,
   parameter int unsigned SPIN_S  = 60
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Sec_Tick,
   input  logic             Coin_In,
   input  logic             Double_Wash,
   input  logic             Timer_Pause,
   output logic [2:0]       Phase,
   output logic [CNT_W-1:0] Sec_Remaining,
   output logic             Phase_Start,
   output logic             Wash_Done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_FILL  = 3'b001,
      S_WASH  = 3'b010,
      S_RINSE = 3'b011,
      S_SPIN  = 3'b100
   } state_t;

   localparam logic [CNT_W-1:0] FILL_D  = CNT_W'(FILL_S);
   localparam logic [CNT_W-1:0] WASH_D  = CNT_W'(WASH_S);
   localparam logic [CNT_W-1:0] RINSE_D = CNT_W'(RINSE_S);
   localparam logic [CNT_W-1:0] SPIN_D  = CNT_W'(SPIN_S);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dbl_q, dbl_d;
   logic             pass_q, pass_d;
   logic             start_q, start_d;
   logic             done_q, done_d;

   logic [CNT_W-1:0] dur;
   logic             tick_ok;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dbl_q   <= 1'b0;
         pass_q  <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dbl_q   <= dbl_d;
         pass_q  <= pass_d;
         start_q <= start_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      dur = '0;
      case (state_q)
         S_FILL:  dur = FILL_D;
         S_WASH:  dur = WASH_D;
         S_RINSE: dur = RINSE_D;
         S_SPIN:  dur = SPIN_D;
         default: dur = '0;
      endcase
   end

   // Pause only gates the tick while spinning; elsewhere the tick always counts.
   assign tick_ok = Sec_Tick && !((state_q == S_SPIN) && Timer_Pause);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dbl_d   = dbl_q;
      pass_d  = pass_q;
      start_d = 1'b0;
      done_d  = done_q;
      if (state_q == S_IDLE) begin
         if (Coin_In) begin
            state_d = S_FILL;
            cnt_d   = '0;
            dbl_d   = Double_Wash;
            pass_d  = 1'b0;
            done_d  = 1'b0;
            start_d = 1'b1;
         end
      end else if (tick_ok) begin
         if (cnt_q == dur - CNT_W'(1)) begin
            cnt_d   = '0;
            start_d = 1'b1;
            case (state_q)
               S_FILL:  state_d = S_WASH;
               S_WASH:  state_d = S_RINSE;
               S_RINSE: begin
                  if (dbl_q && !pass_q) begin
                     state_d = S_WASH;
                     pass_d  = 1'b1;
                  end else begin
                     state_d = S_SPIN;
                  end
               end
               S_SPIN: begin
                  state_d = S_IDLE;
                  start_d = 1'b0;
                  done_d  = 1'b1;
               end
               default: state_d = S_IDLE;
            endcase
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign Phase         = state_q;
   assign Sec_Remaining = (state_q == S_IDLE) ? '0 : dur - cnt_q;
   assign Phase_Start   = start_q;
   assign Wash_Done     = done_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl with short phase durations (2/3/2/2 s)
// and one Sec_Tick every 10 Clk.
module tb_wash_cycle_ctrl;

   localparam int unsigned CNT_W = 9;

   logic             Clk = 1'b0;
   logic             Rst = 1'b0;
   logic             Sec_Tick = 1'b0;
   logic             Coin_In = 1'b0;
   logic             Double_Wash = 1'b0;
   logic             Timer_Pause = 1'b0;
   logic [2:0]       Phase;
   logic [CNT_W-1:0] Sec_Remaining;
   logic             Phase_Start;
   logic             Wash_Done;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   int unsigned ps_cnt  = 0;
   logic [2:0]  ph_prev = 3'b000;
   logic [2:0]  ph_log[$];

   wash_cycle_ctrl #(
      .CNT_W  (CNT_W),
      .FILL_S (2),
      .WASH_S (3),
      .RINSE_S(2),
      .SPIN_S (2)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .Sec_Tick     (Sec_Tick),
      .Coin_In      (Coin_In),
      .Double_Wash  (Double_Wash),
      .Timer_Pause  (Timer_Pause),
      .Phase        (Phase),
      .Sec_Remaining(Sec_Remaining),
      .Phase_Start  (Phase_Start),
      .Wash_Done    (Wash_Done)
   );

   always #5 Clk = ~Clk;

   // Records every Phase change and every Phase_Start pulse.
   always @(negedge Clk) begin
      if (Phase_Start) ps_cnt <= ps_cnt + 1;
      if (Phase != ph_prev) ph_log.push_back(Phase);
      ph_prev <= Phase;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Nine idle cycles then one cycle carrying the tick; returns just after that edge.
   task automatic sec(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         Sec_Tick = 1'b0;
         repeat (9) step();
         Sec_Tick = 1'b1;
         step();
         Sec_Tick = 1'b0;
      end
   endtask

   task automatic chk_seq(input string tag, input int unsigned base, input logic [2:0] exp[]);
      chk({tag, "_len"}, ph_log.size() - base, exp.size());
      for (int unsigned i = 0; i < exp.size(); i++) begin
         if (base + i < ph_log.size()) chk(tag, ph_log[base+i], exp[i]);
         else chk(tag, 3'b111, exp[i]);
      end
   endtask

   initial begin
      int unsigned base_ps;
      int unsigned base_log;
      logic [2:0] seq1[] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      logic [2:0] seq2[] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd0};

      // Reset state
      repeat (3) step();
      chk("rst_phase", Phase, 3'd0);
      chk("rst_rem", Sec_Remaining, 0);
      chk("rst_start", Phase_Start, 0);
      chk("rst_done", Wash_Done, 0);
      Rst = 1'b1;
      repeat (2) step();

      // Single cycle
      base_ps  = ps_cnt;
      base_log = ph_log.size();
      Coin_In = 1'b1; Double_Wash = 1'b0;
      step();
      Coin_In = 1'b0;
      chk("t1_fill", Phase, 3'd1);
      chk("t1_fill_start", Phase_Start, 1);
      chk("t1_fill_rem2", Sec_Remaining, 2);
      step();
      chk("t1_start_low", Phase_Start, 0);
      sec(1);
      chk("t1_fill_still", Phase, 3'd1);
      chk("t1_fill_rem1", Sec_Remaining, 1);
      sec(1);
      chk("t1_wash", Phase, 3'd2);
      chk("t1_wash_start", Phase_Start, 1);
      chk("t1_wash_rem3", Sec_Remaining, 3);
      sec(2);
      chk("t1_wash_rem1", Sec_Remaining, 1);
      sec(1);
      chk("t1_rinse", Phase, 3'd3);
      sec(2);
      chk("t1_spin", Phase, 3'd4);
      chk("t1_spin_rem", Sec_Remaining, 2);
      sec(2);
      chk("t1_idle", Phase, 3'd0);
      chk("t1_done", Wash_Done, 1);
      chk("t1_idle_start", Phase_Start, 0);
      chk("t1_idle_rem", Sec_Remaining, 0);
      step();
      chk("t1_ps_count", ps_cnt - base_ps, 4);
      chk_seq("t1_seq", base_log, seq1);

      // Double wash; Double_Wash dropped, pause and coin applied during WASH
      base_ps  = ps_cnt;
      base_log = ph_log.size();
      Coin_In = 1'b1; Double_Wash = 1'b1;
      step();
      Coin_In = 1'b0;
      chk("t2_done_clr", Wash_Done, 0);
      sec(2);
      chk("t2_wash1", Phase, 3'd2);
      Double_Wash = 1'b0; Timer_Pause = 1'b1;
      sec(1);
      Coin_In = 1'b1;
      step();
      Coin_In = 1'b0;
      chk("t2_coin_ign_ph", Phase, 3'd2);
      chk("t2_coin_ign_rem", Sec_Remaining, 2);
      sec(2);
      chk("t2_rinse1", Phase, 3'd3);
      Timer_Pause = 1'b0;
      sec(2);
      chk("t2_wash2", Phase, 3'd2);
      chk("t2_wash2_start", Phase_Start, 1);
      sec(3);
      chk("t2_rinse2", Phase, 3'd3);
      sec(2);
      chk("t2_spin", Phase, 3'd4);
      sec(2);
      chk("t2_idle", Phase, 3'd0);
      chk("t2_done", Wash_Done, 1);
      step();
      chk("t2_ps_count", ps_cnt - base_ps, 6);
      chk_seq("t2_seq", base_log, seq2);

      // Pause in SPIN
      Coin_In = 1'b1;
      step();
      Coin_In = 1'b0;
      sec(7);
      chk("t3_spin", Phase, 3'd4);
      sec(1);
      chk("t3_spin_rem1", Sec_Remaining, 1);
      Timer_Pause = 1'b1;
      sec(3);
      chk("t3_paused_ph", Phase, 3'd4);
      chk("t3_paused_rem", Sec_Remaining, 1);
      Timer_Pause = 1'b0;
      sec(1);
      chk("t3_resume_idle", Phase, 3'd0);
      chk("t3_done", Wash_Done, 1);

      // Tick coincident with coin
      Coin_In = 1'b1; Sec_Tick = 1'b1;
      step();
      Coin_In = 1'b0; Sec_Tick = 1'b0;
      chk("t4_fill", Phase, 3'd1);
      chk("t4_rem2", Sec_Remaining, 2);
      chk("t4_done_clr", Wash_Done, 0);
      step();
      chk("t4_rem2_hold", Sec_Remaining, 2);

      // Async reset mid-RINSE with ticks running
      sec(5);
      chk("t5_rinse", Phase, 3'd3);
      sec(1);
      Sec_Tick = 1'b1; Rst = 1'b0;
      #1;
      chk("t5_rst_phase", Phase, 3'd0);
      chk("t5_rst_rem", Sec_Remaining, 0);
      chk("t5_rst_start", Phase_Start, 0);
      chk("t5_rst_done", Wash_Done, 0);
      step();
      sec(2);
      Rst = 1'b1;
      sec(2);
      chk("t5_wait_idle", Phase, 3'd0);

      // Coin held high: restart after exactly one IDLE cycle
      Coin_In = 1'b1;
      step();
      chk("t6_fill", Phase, 3'd1);
      chk("t6_fill_rem", Sec_Remaining, 2);
      sec(7);
      chk("t6_spin", Phase, 3'd4);
      sec(2);
      chk("t6_idle", Phase, 3'd0);
      chk("t6_done_hi", Wash_Done, 1);
      step();
      chk("t6_refill", Phase, 3'd1);
      chk("t6_done_lo", Wash_Done, 0);
      chk("t6_refill_start", Phase_Start, 1);
      Coin_In = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
